// File: rtl/amm_mem_responder.sv
// Avalon-MM slave memory model: burst reads/writes with byte enables, fixed read latency.
// Define AMM_MEM_RESP_ERR_INJECT_EN to enable read-data bit-0 error injection.
module amm_mem_responder #(
  parameter int AMM_DATA_W  = 64,
  parameter int AMM_ADDR_W  = 31,
  parameter int AMM_BURST_W = 11,
  parameter int DATA_B_W    = AMM_DATA_W / 8,
  parameter int MEM_ADDR_W  = 10,
  parameter int RD_LATENCY  = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [AMM_ADDR_W-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  input  logic [AMM_DATA_W-1:0]  writedata_i,
  input  logic [AMM_BURST_W-1:0] burstcount_i,
  input  logic [DATA_B_W-1:0]    byteenable_i,
  input  logic                   stall_i,
  output logic                   waitrequest_o,
  output logic                   readdatavalid_o,
  output logic [AMM_DATA_W-1:0]  readdata_o,
  input  logic                   err_en_i,
  input  logic [MEM_ADDR_W-1:0]  err_addr_i
);
  localparam int DEPTH  = 2 ** MEM_ADDR_W;
  localparam int WAIT_W = (RD_LATENCY > 2) ? $clog2(RD_LATENCY) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = (RD_LATENCY > 1) ? WAIT_W'(RD_LATENCY - 2) : '0;

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_WAIT, RD_DATA} state_t;

  state_t                 state_q;
  logic [AMM_BURST_W-1:0] cnt_q;
  logic [MEM_ADDR_W-1:0]  ptr_q;
  logic [MEM_ADDR_W-1:0]  out_idx_q;
  logic [WAIT_W-1:0]      wait_q;
  logic                   rvalid_q;
  logic [AMM_DATA_W-1:0]  rdata_q;
  logic [AMM_DATA_W-1:0]  mem [DEPTH];

  logic [MEM_ADDR_W-1:0]  base_idx;
  logic [AMM_BURST_W-1:0] burst_n;
  logic                   accept;
  logic                   wr_acc;
  logic                   rd_acc;
  logic                   rd_en;
  logic [MEM_ADDR_W-1:0]  wr_idx;
  logic [MEM_ADDR_W-1:0]  rd_idx;

  assign base_idx      = address_i[MEM_ADDR_W-1:0];
  assign burst_n       = (burstcount_i == '0) ? AMM_BURST_W'(1) : burstcount_i;
  assign waitrequest_o = stall_i | rst_i | (state_q == RD_WAIT) | (state_q == RD_DATA);
  assign accept        = (read_i | write_i) & ~waitrequest_o;
  assign wr_acc        = accept & write_i;
  // A read together with a write is dropped, as is any read inside a write burst.
  assign rd_acc        = accept & ~write_i & read_i & (state_q == IDLE);
  assign wr_idx        = (state_q == IDLE) ? base_idx : ptr_q;
  assign rd_idx        = (state_q == IDLE) ? base_idx : ptr_q;
  assign rd_en         = (rd_acc && (RD_LATENCY == 1))
                       | ((state_q == RD_WAIT) && (wait_q == '0))
                       | ((state_q == RD_DATA) && (cnt_q != '0));

  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      for (int b = 0; b < DATA_B_W; b++) begin
        if (byteenable_i[b]) mem[wr_idx][b*8 +: 8] <= writedata_i[b*8 +: 8];
      end
    end
  end

  // cnt_q counts write beats still expected, or read words still to fetch.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      out_idx_q <= '0;
      wait_q    <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (rd_en) begin
        rdata_q   <= mem[rd_idx];
        out_idx_q <= rd_idx;
      end
      case (state_q)
        IDLE: begin
          if (wr_acc) begin
            if (burst_n != AMM_BURST_W'(1)) begin
              state_q <= WR_BURST;
              cnt_q   <= burst_n - 1'b1;
              ptr_q   <= base_idx + 1'b1;
            end
          end else if (rd_acc) begin
            if (RD_LATENCY == 1) begin
              state_q  <= RD_DATA;
              rvalid_q <= 1'b1;
              cnt_q    <= burst_n - 1'b1;
              ptr_q    <= base_idx + 1'b1;
            end else begin
              state_q <= RD_WAIT;
              wait_q  <= WAIT_INIT;
              cnt_q   <= burst_n;
              ptr_q   <= base_idx;
            end
          end
        end
        WR_BURST: begin
          if (wr_acc) begin
            ptr_q <= ptr_q + 1'b1;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == AMM_BURST_W'(1)) state_q <= IDLE;
          end
        end
        RD_WAIT: begin
          if (wait_q == '0) begin
            state_q  <= RD_DATA;
            rvalid_q <= 1'b1;
            cnt_q    <= cnt_q - 1'b1;
            ptr_q    <= ptr_q + 1'b1;
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        RD_DATA: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
            ptr_q <= ptr_q + 1'b1;
          end else begin
            rvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign readdatavalid_o = rvalid_q;

`ifdef AMM_MEM_RESP_ERR_INJECT_EN
  logic inject;
  assign inject     = rvalid_q & err_en_i & (out_idx_q == err_addr_i);
  assign readdata_o = {rdata_q[AMM_DATA_W-1:1], rdata_q[0] ^ inject};
`else
  logic unused_err;
  assign unused_err = &{1'b0, err_en_i, err_addr_i, out_idx_q};
  assign readdata_o = rdata_q;
`endif

  logic unused_addr;
  assign unused_addr = &{1'b0, address_i[AMM_ADDR_W-1:MEM_ADDR_W]};

endmodule

// File: tb/tb_amm_mem_responder.sv
// Randomized bench for amm_mem_responder: behavioural memory/timing model plus directed literal checks.
module tb_amm_mem_responder;
  localparam int DW = 64, AW = 31, BW = 11, NB = 8, MAW = 10, LAT = 2, DEPTH = 1024;

  logic           clk_i = 1'b0, rst_i = 1'b0, read_i = 1'b0, write_i = 1'b0, stall_i = 1'b0;
  logic [AW-1:0]  address_i = '0;
  logic [DW-1:0]  writedata_i = '0;
  logic [BW-1:0]  burstcount_i = '0;
  logic [NB-1:0]  byteenable_i = '0;
  logic           err_en_i = 1'b0;
  logic [MAW-1:0] err_addr_i = '0;
  logic           waitrequest_o, readdatavalid_o;
  logic [DW-1:0]  readdata_o;

  amm_mem_responder #(.AMM_DATA_W(DW), .AMM_ADDR_W(AW), .AMM_BURST_W(BW), .DATA_B_W(NB),
                      .MEM_ADDR_W(MAW), .RD_LATENCY(LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .address_i(address_i), .read_i(read_i), .write_i(write_i),
    .writedata_i(writedata_i), .burstcount_i(burstcount_i), .byteenable_i(byteenable_i),
    .stall_i(stall_i), .waitrequest_o(waitrequest_o), .readdatavalid_o(readdatavalid_o),
    .readdata_o(readdata_o), .err_en_i(err_en_i), .err_addr_i(err_addr_i));

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endfunction

  // Reference model: word array, pending-beat queue, busy window, open write burst.
  typedef struct { int cyc; int idx; } beat_t;
  logic [DW-1:0] mem_m [DEPTH];
  beat_t         exp_q [$];
  int busy_from = 0, busy_to = -1, wr_left = 0, wr_ptr = 0, rd_acc_cyc = 0;
  logic [DW-1:0] got_q [$];
  int            got_cyc [$];

  always @(negedge clk_i) begin
    logic exp_wr, exp_rdv, acc;
    logic [DW-1:0] exp_d;
    beat_t bt;
    int n, idx;
    exp_wr  = stall_i | rst_i | (cyc >= busy_from && cyc <= busy_to);
    exp_rdv = !rst_i && exp_q.size() > 0 && exp_q[0].cyc == cyc;
    chk("waitrequest", waitrequest_o, exp_wr);
    chk("readdatavalid", readdatavalid_o, exp_rdv);
    if (readdatavalid_o) begin
      got_q.push_back(readdata_o);
      got_cyc.push_back(cyc);
    end
    if (rst_i) begin
      chk("readdata_in_reset", readdata_o, 64'h0);
      exp_q.delete();
      busy_to = -1;
      wr_left = 0;
    end else begin
      if (exp_rdv) begin
        bt = exp_q.pop_front();
        exp_d = mem_m[bt.idx];
`ifdef AMM_MEM_RESP_ERR_INJECT_EN
        if (err_en_i && bt.idx == int'(err_addr_i)) exp_d[0] = ~exp_d[0];
`endif
        chk("readdata", readdata_o, exp_d);
      end
      acc = (read_i | write_i) && !exp_wr;
      n = (burstcount_i == 0) ? 1 : int'(burstcount_i);
      if (acc && write_i) begin
        if (wr_left == 0) begin
          idx = int'(address_i[MAW-1:0]);
          if (n > 1) begin wr_left = n - 1; wr_ptr = (idx + 1) % DEPTH; end
        end else begin
          idx = wr_ptr;
          wr_ptr = (wr_ptr + 1) % DEPTH;
          wr_left--;
        end
        for (int b = 0; b < NB; b++)
          if (byteenable_i[b]) mem_m[idx][b*8 +: 8] = writedata_i[b*8 +: 8];
      end else if (acc && read_i && wr_left == 0) begin
        idx = int'(address_i[MAW-1:0]);
        for (int i = 0; i < n; i++) exp_q.push_back('{cyc + LAT + i, (idx + i) % DEPTH});
        busy_from  = cyc + 1;
        busy_to    = cyc + LAT + n - 1;
        rd_acc_cyc = cyc;
      end
    end
  end

  logic stall_hold = 1'b0, rand_stall = 1'b0, rand_err = 1'b0;
  always @(posedge clk_i) begin
    #2;
    stall_i = stall_hold | (rand_stall && $urandom_range(0, 5) == 0);
    if (rand_err) begin
      err_en_i = 1'($urandom_range(0, 1));
      if (exp_q.size() > 0 && $urandom_range(0, 1) == 1) err_addr_i = MAW'(exp_q[0].idx);
      else err_addr_i = MAW'($urandom);
    end
  end

  logic [DW-1:0] wdata_a [DEPTH];
  logic [NB-1:0] be_a    [DEPTH];

  task automatic wait_accept(output bit ok);
    bit acc;
    ok = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk_i);
      acc = !waitrequest_o;
      @(posedge clk_i); #1;
      if (acc) begin ok = 1; return; end
    end
    checks++; errors++;
    $display("FAIL accept_timeout at cycle %0d: got no acceptance expected acceptance", cyc);
  endtask

  task automatic wr_burst(input logic [AW-1:0] addr, input logic [BW-1:0] bc, input int stall_at, input bit rnd);
    int n;
    bit ok;
    n = (bc == 0) ? 1 : int'(bc);
    for (int i = 0; i < n; i++) begin
      if (rnd && i > 0 && $urandom_range(0, 4) == 0) begin
        write_i = 0; read_i = 1'($urandom_range(0, 1));
        @(posedge clk_i); #1;
      end
      address_i    = (i == 0) ? addr : AW'($urandom);
      burstcount_i = (i == 0) ? bc : BW'($urandom);
      writedata_i  = wdata_a[i];
      byteenable_i = be_a[i];
      write_i      = 1;
      read_i       = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      if (i == stall_at) begin
        stall_hold = 1;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        stall_hold = 0;
      end
      wait_accept(ok);
      if (!ok) break;
    end
    write_i = 0; read_i = 0;
  endtask

  task automatic rd(input logic [AW-1:0] addr, input logic [BW-1:0] bc);
    bit ok;
    address_i = addr; burstcount_i = bc; byteenable_i = NB'($urandom);
    read_i = 1; write_i = 0;
    wait_accept(ok);
    read_i = 0;
  endtask

  task automatic rd_get(input logic [AW-1:0] addr, input logic [BW-1:0] bc, input int n);
    got_q.delete(); got_cyc.delete();
    rd(addr, bc);
    for (int t = 0; t < 100 && got_q.size() < n; t++) begin @(posedge clk_i); #1; end
    if (got_q.size() < n) begin
      checks++; errors++;
      $display("FAIL read_timeout: got %0d beats expected %0d", got_q.size(), n);
      for (int i = got_q.size(); i < n; i++) begin got_q.push_back('0); got_cyc.push_back(0); end
    end
  endtask

  task automatic wr1(input logic [AW-1:0] addr, input logic [DW-1:0] d, input logic [NB-1:0] be);
    wdata_a[0] = d; be_a[0] = be;
    wr_burst(addr, 1, -1, 0);
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [BW-1:0] bc;
    #1 rst_i = 1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_waitrequest", waitrequest_o, 1);
    chk("rst_readdatavalid", readdatavalid_o, 0);
    chk("rst_readdata", readdata_o, 0);
    @(posedge clk_i); #1 rst_i = 0;
    @(negedge clk_i);
    chk("post_rst_waitrequest", waitrequest_o, 0);
    @(posedge clk_i); #1;

    for (int i = 0; i < DEPTH; i++) begin wdata_a[i] = {$urandom, $urandom}; be_a[i] = 8'hFF; end
    wr_burst(0, BW'(DEPTH), -1, 0);

    wr1(5, 64'h0123_4567_89AB_CDEF, 8'hFF);
    rd_get(5, 1, 1);
    chk("single_data", got_q[0], 64'h0123_4567_89AB_CDEF);
    chk("single_latency", 64'(got_cyc[0] - rd_acc_cyc), 64'd2);

    wr1(7, 64'h0, 8'hFF);
    wr1(7, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    rd_get(7, 1, 1);
    chk("byteenable_data", got_q[0], 64'h0000_0000_FFFF_FFFF);

    for (int i = 0; i < 4; i++) begin wdata_a[i] = 64'(i + 1); be_a[i] = 8'hFF; end
    wr_burst(AW'(32'h7000_03FE), 4, 2, 0);
    rd_get(1022, 4, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("wrap_beat%0d", i), got_q[i], 64'(i + 1));
    chk("wrap_consecutive", 64'(got_cyc[3] - got_cyc[0]), 64'd3);
    rd_get(0, 2, 2);
    chk("wrap_word0", got_q[0], 64'd3);
    chk("wrap_word1", got_q[1], 64'd4);

    wr1(5, 64'h10, 8'hFF);
    err_en_i = 1; err_addr_i = 5;
    rd_get(5, 1, 1);
`ifdef AMM_MEM_RESP_ERR_INJECT_EN
    chk("inject_on", got_q[0], 64'h11);
`else
    chk("inject_on", got_q[0], 64'h10);
`endif
    err_en_i = 0;
    rd_get(5, 1, 1);
    chk("inject_off", got_q[0], 64'h10);

    got_q.delete(); got_cyc.delete();
    rd(100, 8);
    for (int t = 0; t < 50 && got_q.size() < 3; t++) begin @(posedge clk_i); #1; end
    rst_i = 1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1 rst_i = 0;
    repeat (12) @(posedge clk_i);
    #1;
    chk("rst_mid_read_beats", 64'(got_q.size()), 64'd3);
    rd_get(100, 2, 2);
    chk("after_rst_read", got_q[0], mem_m[100]);

    rand_stall = 1; rand_err = 1;
    for (int op = 0; op < 250; op++) begin
      a = AW'($urandom);
      if ($urandom_range(0, 3) == 0) a[MAW-1:0] = MAW'(1020 + $urandom_range(0, 3));
      bc = BW'($urandom_range(0, 8));
      if ($urandom_range(0, 9) < 6) begin
        for (int i = 0; i < 8; i++) begin wdata_a[i] = {$urandom, $urandom}; be_a[i] = NB'($urandom); end
        wr_burst(a, bc, -1, 1);
      end else begin
        rd(a, bc);
      end
    end
    rand_stall = 0; rand_err = 0;
    repeat (30) @(posedge clk_i);
    #1;
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
